// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the SDF FFT stage control units.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} sdf_state_e;

  localparam int unsigned DEF_BF_HALF     = 2;
  localparam int unsigned DEF_FRAME_BEATS = 32;

  // Exact log2 of a power of two; used to pick the bf_en bit out of in_cnt.
  function automatic int unsigned log2_pow2(input int unsigned n);
    int unsigned r = 0;
    for (int unsigned i = n; i > 1; i = i >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mod_cnt.sv
// Modulo-N up-counter with enable, async active-low clear and terminal-count flag.
module mod_cnt
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned N = DEF_FRAME_BEATS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  output logic [$clog2(N)-1:0] cnt,
  output logic                 tc
);

  localparam int unsigned   W    = $clog2(N);
  localparam logic [W-1:0]  LAST = W'(N - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/cu_mod1_seq.sv
// Sequencer for one SDF radix-2 butterfly stage: fill, run, drain control,
// butterfly mode, output valid, twiddle address and frame-done pulse.
module cu_mod1_seq
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned BF_HALF     = DEF_BF_HALF,
  parameter int unsigned FRAME_BEATS = DEF_FRAME_BEATS
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           valid,
  output logic                           shift_en,
  output logic                           bf_en,
  output logic                           valid_out,
  output logic [$clog2(FRAME_BEATS)-1:0] tw_addr,
  output logic                           frame_done,
  output logic                           busy
);

  localparam int unsigned   TW_W       = $clog2(FRAME_BEATS);
  localparam int unsigned   BF_LOG2    = log2_pow2(BF_HALF);
  localparam int unsigned   HW         = $clog2(BF_HALF + 1);
  localparam logic [HW-1:0] HALF_CNT   = HW'(BF_HALF);
  localparam logic [HW-1:0] DRAIN_LAST = HW'(BF_HALF - 1);

  sdf_state_e      state_q, state_d;
  logic [HW-1:0]   fill_q, fill_d;
  logic [HW-1:0]   drain_q, drain_d;
  logic [TW_W-1:0] in_cnt, out_cnt;
  logic            in_tc, out_tc;
  logic            in_zero_q;
  logic            drain_beat;

  mod_cnt #(.N(FRAME_BEATS)) u_in_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (valid),
    .cnt  (in_cnt),
    .tc   (in_tc)
  );

  mod_cnt #(.N(FRAME_BEATS)) u_out_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (valid_out),
    .cnt  (out_cnt),
    .tc   (out_tc)
  );

  // in_zero_q mirrors (in_cnt == 0): set when the accepted beat wraps the counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      drain_q   <= '0;
      in_zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      drain_q <= drain_d;
      if (valid) in_zero_q <= in_tc;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    drain_d    = drain_q;
    drain_beat = (state_q == DRAIN);
    shift_en   = rstn & (valid | drain_beat);
    valid_out  = rstn & ((valid & (state_q == RUN)) | drain_beat);
    frame_done = valid_out & out_tc;

    unique case (state_q)
      IDLE: begin
        if (valid) begin
          fill_d  = HW'(1);
          state_d = (BF_HALF == 1) ? RUN : FILL;
        end
      end
      FILL: begin
        if (valid) begin
          fill_d = fill_q + 1'b1;
          if (fill_d == HALF_CNT) state_d = RUN;
        end
      end
      RUN: begin
        if (!valid && in_zero_q) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        // A fresh beat during drain pushes the old data out as a normal RUN beat.
        if (valid) begin
          state_d = RUN;
          drain_d = '0;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bf_en   = in_cnt[BF_LOG2];
  assign tw_addr = out_cnt;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_cu_mod1_seq.sv
// Scoreboard bench for cu_mod1_seq (BF_HALF=2, FRAME_BEATS=32).
module tb_cu_mod1_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       valid;
  logic       shift_en, bf_en, valid_out, frame_done, busy;
  logic [4:0] tw_addr;

  typedef struct {
    logic [4:0] tw;
    logic       fd;
    logic       bf;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cu_mod1_seq #(.BF_HALF(2), .FRAME_BEATS(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid      (valid),
    .shift_en   (shift_en),
    .bf_en      (bf_en),
    .valid_out  (valid_out),
    .tw_addr    (tw_addr),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_shift_en"},   32'(shift_en),   0);
    chk({tag, "_bf_en"},      32'(bf_en),      0);
    chk({tag, "_valid_out"},  32'(valid_out),  0);
    chk({tag, "_tw_addr"},    32'(tw_addr),    0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_busy"},       32'(busy),       0);
  endtask

  // One clock cycle of stimulus; pushes the expected output beat if one is due.
  task automatic cyc(input bit v, input bit eo, input int tw, input bit fd,
                     input bit bf, input bit bz);
    exp_t e;
    @(negedge clk);
    valid = v;
    if (eo) begin
      e.tw = 5'(tw);
      e.fd = fd;
      e.bf = bf;
      sb.push_back(e);
    end
    #2;
    chk("bf_en", 32'(bf_en), 32'(bf));
    chk("busy", 32'(busy), 32'(bz));
    chk("shift_en", 32'(shift_en), 32'(v | (eo & ~v)));
  endtask

  // Full 32-beat frame starting from IDLE: two fill beats, then outputs 0..29.
  task automatic frame_from_idle();
    for (int k = 0; k < 32; k++)
      cyc(1'b1, k >= 2, k - 2, 1'b0, 1'(((k / 2) % 2)), k != 0);
  endtask

  // Boundary cycle (no output), two drain beats (30, 31 with frame_done), then IDLE.
  task automatic boundary_drain();
    cyc(1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 30, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 31, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_valid_out: got valid_out=1 tw_addr=%0d, expected valid_out=0", tw_addr);
        end else begin
          e = sb.pop_front();
          chk("out_tw_addr",    32'(tw_addr),    32'(e.tw));
          chk("out_frame_done", 32'(frame_done), 32'(e.fd));
          chk("out_bf_en",      32'(bf_en),      32'(e.bf));
        end
      end else begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_vec++;
          n_fail++;
          $display("FAIL missing_valid_out: got valid_out=%b, expected 1 for tw_addr=%0d", valid_out, e.tw);
        end
        chk("idle_frame_done", 32'(frame_done), 0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rstn  = 1'b0;
    valid = 1'b0;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Single frame, fill, run, drain; bf_en pattern over the frame.
    frame_from_idle();
    boundary_drain();

    // Two back-to-back frames: no drain in between, tw_addr wraps.
    for (int k = 0; k < 64; k++)
      cyc(1'b1, k >= 2, (k - 2) % 32, ((k - 2) % 32) == 31, 1'(((k / 2) % 2)), k != 0);
    boundary_drain();

    // Gap of three cycles after beat 10: everything holds.
    for (int k = 0; k <= 10; k++)
      cyc(1'b1, k >= 2, k - 2, 1'b0, 1'(((k / 2) % 2)), k != 0);
    for (int g = 0; g < 3; g++) begin
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
      chk("gap_tw_addr", 32'(tw_addr), 9);
      chk("gap_valid_out", 32'(valid_out), 0);
    end
    for (int k = 11; k < 32; k++)
      cyc(1'b1, 1'b1, k - 2, 1'b0, 1'(((k / 2) % 2)), 1'b1);
    boundary_drain();

    // New beat after one drain cycle: straight back to RUN.
    frame_from_idle();
    cyc(1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 30, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 31, 1'b1, 1'b0, 1'b1);
    for (int m = 1; m <= 17; m++)
      cyc(1'b1, 1'b1, m - 1, 1'b0, 1'(((m / 2) % 2)), 1'b1);

    // Asynchronous reset between edges during beat 17, valid still high.
    #1;
    rstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    valid = 1'b0;
    rstn  = 1'b1;

    // Restart after reset: fill again, first output on the third beat.
    for (int k = 0; k < 6; k++)
      cyc(1'b1, k >= 2, k - 2, 1'b0, 1'(((k / 2) % 2)), k != 0);
    for (int g = 0; g < 3; g++)
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);

    @(negedge clk);
    #3;
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
